// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid,
// synchronous flush and saturating stall/bubble counters.
module pipe_skid_stage #(
  parameter int unsigned    DW      = 72,
  parameter logic [DW-1:0]  NOP_VAL = '0,
  parameter int unsigned    SKID    = 1,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [DW-1:0]    m_q, m_d;
  logic [DW-1:0]    s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             acc, pop;

  // Without the skid entry, in_ready must look through to out_ready to keep full rate.
  assign in_ready   = (SKID != 0) ? in_ready_q : ((state_q == EMPTY) | out_ready);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = m_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign acc        = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  // Next-state, storage and counter update; flush overrides every other event.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    s_d      = s_q;
    stall_d  = stall_q;
    bubble_d = bubble_q;

    if (flush) begin
      state_d = EMPTY;
      m_d     = NOP_VAL;
      s_d     = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            m_d     = in_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            m_d = in_data;
          end else if (acc && (SKID != 0)) begin
            state_d = FULL;
            s_d     = in_data;
          end else if (pop) begin
            state_d = EMPTY;
            m_d     = NOP_VAL;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = NOP_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = NOP_VAL;
          s_d     = NOP_VAL;
        end
      endcase
    end

    in_ready_d = (state_d != FULL);

    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
      if (!out_valid && !flush && (bubble_q != CNT_MAX)) bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= NOP_VAL;
      s_q        <= NOP_VAL;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: default skid build plus a SKID=0, CNT_W=4 build.
module tb_pipe_skid_stage;

  localparam int unsigned DW  = 72;
  localparam int unsigned ZW  = 8;
  localparam int unsigned ZCW = 4;
  localparam logic [ZW-1:0] Z_NOP = 8'hA5;

  localparam logic [DW-1:0] VA = 72'hAA_0000_0000_0000_00A1;
  localparam logic [DW-1:0] VB = 72'hBB_0000_0000_0000_00B2;
  localparam logic [DW-1:0] VC = 72'hCC_0000_0000_0000_00C3;
  localparam logic [DW-1:0] VD = 72'hDD_0000_0000_0000_00D4;
  localparam logic [DW-1:0] VE = 72'hEE_0000_0000_0000_00E5;
  localparam logic [DW-1:0] VF = 72'hFF_0000_0000_0000_00F6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   stall_cnt, bubble_cnt;

  logic           z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_cnt_clr;
  logic [ZW-1:0]  z_in_data, z_out_data;
  logic [ZCW-1:0] z_stall_cnt, z_bubble_cnt;

  pipe_skid_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_skid_stage #(.DW(ZW), .NOP_VAL(Z_NOP), .SKID(0), .CNT_W(ZCW)) u_dut0 (
    .clk(clk), .rst(rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_data(z_in_data), .in_ready(z_in_ready),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(z_out_ready),
    .cnt_clr(z_cnt_clr), .stall_cnt(z_stall_cnt), .bubble_cnt(z_bubble_cnt)
  );

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every consumed head against the scoreboard, idle outputs against NOP.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %0h want none (t=%0t)", out_data, $time);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end else if (!out_valid) begin
        chk("idle_nop", out_data, '0);
      end
      if (flush) exp_q.delete();
    end
  end

  // One clock of main-DUT stimulus; accepted payloads go to the scoreboard.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic fl, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    @(negedge clk);
    if (iv && in_ready && !fl && !rst) exp_q.push_back(d);
  endtask

  task automatic zcyc(input logic iv, input logic [ZW-1:0] d, input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    z_in_valid  = iv;
    z_in_data   = d;
    z_out_ready = ordy;
    z_cnt_clr   = clr;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pop0;
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = '0; z_out_ready = 1'b0; z_cnt_clr = 1'b0;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), 1);
    chk("z_rst_out_data", DW'(z_out_data), DW'(Z_NOP));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill to FULL, then assert reset asynchronously mid-cycle.
    cyc(1'b1, VA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, VB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VC, 1'b0, 1'b0, 1'b0);
    chk("full_in_ready", DW'(in_ready), 0);
    chk("full_out_valid", DW'(out_valid), 1);
    chk("full_head", out_data, VA);
    chk("full_stall", DW'(stall_cnt), 1);
    chk("full_bubble", DW'(bubble_cnt), 0);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", DW'(out_valid), 0);
    chk("arst_out_data", out_data, '0);
    chk("arst_in_ready", DW'(in_ready), 1);
    chk("arst_stall", DW'(stall_cnt), 0);
    chk("arst_bubble", DW'(bubble_cnt), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_empty", DW'(out_valid), 0);

    // Streaming 1..8 at full rate.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    pop0 = n_pop;
    for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_pops", DW'(n_pop - pop0), 8);
    chk("stream_bubble", DW'(bubble_cnt), 1);
    chk("stream_stall", DW'(stall_cnt), 0);

    // Skid: A,B captured while stalled, C held upstream until room appears.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, VA, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VC, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready", DW'(in_ready), 0);
    chk("skid_head", out_data, VA);
    cyc(1'b1, VC, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VC, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, VC, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("skid_stall", DW'(stall_cnt), 3);
    chk("skid_bubble", DW'(bubble_cnt), 1);
    chk("skid_drained", DW'(exp_q.size()), 0);

    // Flush in FULL while stalled with D offered: D must never appear.
    cyc(1'b1, VE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VD, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_out_valid", DW'(out_valid), 0);
    chk("flush_out_data", out_data, '0);
    chk("flush_in_ready", DW'(in_ready), 1);
    // Flush in ONE drops an input the stage would otherwise accept.
    cyc(1'b1, VA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_one_drop", DW'(out_valid), 0);
    // Flush with pop: head still consumed that cycle.
    cyc(1'b1, VC, 1'b0, 1'b0, 1'b0);
    pop0 = n_pop;
    cyc(1'b1, VD, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_pop_cnt", DW'(n_pop - pop0), 1);
    chk("flush_pop_empty", DW'(out_valid), 0);
    // Flush cycles are not bubbles.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_no_bubble", DW'(bubble_cnt), 0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bubble_after_flush", DW'(bubble_cnt), 1);

    // SKID=0 build: combinational in_ready and 4-bit saturation.
    zcyc(1'b1, 8'h11, 1'b0, 1'b1);
    zcyc(1'b0, '0, 1'b0, 1'b0);
    chk("z_stall_in_ready", DW'(z_in_ready), 0);
    chk("z_head", DW'(z_out_data), 8'h11);
    zcyc(1'b1, 8'h22, 1'b1, 1'b0);
    chk("z_comb_in_ready", DW'(z_in_ready), 1);
    zcyc(1'b0, '0, 1'b0, 1'b0);
    chk("z_next_head", DW'(z_out_data), 8'h22);
    chk("z_stall_1", DW'(z_stall_cnt), 1);
    repeat (20) zcyc(1'b0, '0, 1'b0, 1'b0);
    chk("z_stall_sat", DW'(z_stall_cnt), 15);
    zcyc(1'b0, '0, 1'b0, 1'b1);
    zcyc(1'b0, '0, 1'b1, 1'b0);
    chk("z_clr_beats_inc", DW'(z_stall_cnt), 0);
    zcyc(1'b0, '0, 1'b1, 1'b0);
    chk("z_empty_valid", DW'(z_out_valid), 0);
    chk("z_empty_nop", DW'(z_out_data), DW'(Z_NOP));

    chk("scoreboard_empty", DW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
